// File: rtl/mdr_sequencer_pkg.sv
// Shared types for the MDR control sequencer: state/op encodings, the
// sequencer register bundle and the per-operation iteration count.
package mdr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAN,
        S_WAIT_X,
        S_WAIT_Y,
        S_VERIFY,
        S_INIT,
        S_CALC,
        S_READY
    } mdr_seq_state_e;

    typedef enum logic [1:0] {
        MDR_OP_MUL  = 2'b00,
        MDR_OP_DIV  = 2'b01,
        MDR_OP_SQRT = 2'b10,
        MDR_OP_RSVD = 2'b11
    } mdr_op_e;

    typedef struct packed {
        mdr_seq_state_e state;
        mdr_op_e        op;
        logic           error;
        logic           timeout;
    } st_mdr_seq;

    // Square root resolves two result bits per iteration; never returns zero.
    function automatic int unsigned mdr_iter(input mdr_op_e op, input int unsigned dw);
        int unsigned n;
        n = (op == MDR_OP_SQRT) ? (dw + 1) / 2 : dw;
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/mdr_iter_counter.sv
// Iteration counter for the CALC phase: loadable terminal count, enable and
// clear; count returns to zero whenever it is not advancing.
module mdr_iter_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] tc_i,
    input  logic          en,
    input  logic          clear,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    logic [CW-1:0] tc;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc    <= '0;
            count <= '0;
        end else begin
            if (load)
                tc <= tc_i;
            if (en && !last_o && !clear)
                count <= count + 1'b1;
            else
                count <= '0;
        end
    end

    assign last_o  = en && (count == tc);
    assign count_o = count;

endmodule

// File: rtl/mdr_sequencer.sv
// Control sequencer for the MDR datapath: one-hot phase strobes, iteration
// count, abort and sticky error. Optional wait timeout: MDR_SEQ_TIMEOUT_EN.
module mdr_sequencer
    import mdr_sequencer_pkg::*;
#(
    parameter int DW      = 16,
    parameter int CW      = $clog2(DW + 1),
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          load_i,
    input  logic [1:0]    op_i,
    input  logic          error_i,
    input  logic          abort_i,
    output logic          clean_o,
    output logic          load_x_o,
    output logic          load_y_o,
    output logic          veri_o,
    output logic          init_o,
    output logic          enable_o,
    output logic          ready_o,
    output logic          error_o,
    output logic          timeout_o,
    output logic          busy_o,
    output logic [1:0]    op_o,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    st_mdr_seq     r;
    st_mdr_seq     r_nxt;
    mdr_op_e       op_in;
    logic          start_acc;
    logic          in_calc;
    logic          in_wait;
    logic          cnt_last;
    logic          wait_expired;
    logic [CW-1:0] iter_tc;

    assign op_in     = mdr_op_e'(op_i);
    assign start_acc = (r.state == S_IDLE) && start_i;
    assign in_calc   = (r.state == S_CALC);
    assign in_wait   = (r.state == S_WAIT_X) || (r.state == S_WAIT_Y);
    assign iter_tc   = CW'(mdr_iter(op_in, DW) - 1);

    mdr_iter_counter #(.CW(CW)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (start_acc),
        .tc_i    (iter_tc),
        .en      (in_calc),
        .clear   (abort_i),
        .count_o (count_o),
        .last_o  (cnt_last)
    );

`ifdef MDR_SEQ_TIMEOUT_EN
    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_cnt;

    // Cleared outside the wait states and on every load, so each wait state starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (!in_wait || load_i)
            wait_cnt <= '0;
        else if (!wait_expired)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign wait_expired = in_wait && !load_i && (wait_cnt == WW'(TIMEOUT));
`else
    logic unused_timeout;
    assign wait_expired   = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r <= '{state: S_IDLE, op: MDR_OP_MUL, error: 1'b0, timeout: 1'b0};
        else
            r <= r_nxt;
    end

    always_comb begin
        r_nxt = r;
        unique case (r.state)
            S_IDLE: begin
                if (start_i) begin
                    r_nxt.state   = S_CLEAN;
                    r_nxt.op      = op_in;
                    r_nxt.error   = 1'b0;
                    r_nxt.timeout = 1'b0;
                end
            end
            S_CLEAN:  r_nxt.state = S_WAIT_X;
            S_WAIT_X: begin
                if (load_i)
                    r_nxt.state = (r.op == MDR_OP_MUL || r.op == MDR_OP_DIV) ? S_WAIT_Y : S_VERIFY;
                else if (wait_expired) begin
                    r_nxt.state   = S_IDLE;
                    r_nxt.error   = 1'b1;
                    r_nxt.timeout = 1'b1;
                end
            end
            S_WAIT_Y: begin
                if (load_i)
                    r_nxt.state = S_VERIFY;
                else if (wait_expired) begin
                    r_nxt.state   = S_IDLE;
                    r_nxt.error   = 1'b1;
                    r_nxt.timeout = 1'b1;
                end
            end
            S_VERIFY: begin
                if (error_i || r.op == MDR_OP_RSVD) begin
                    r_nxt.state = S_IDLE;
                    r_nxt.error = 1'b1;
                end else begin
                    r_nxt.state = S_INIT;
                end
            end
            S_INIT:  r_nxt.state = S_CALC;
            S_CALC:  if (cnt_last) r_nxt.state = S_READY;
            S_READY: r_nxt.state = S_IDLE;
            default: r_nxt.state = S_IDLE;
        endcase
        // Abort overrides every other transition and leaves the sticky flags alone.
        if (abort_i && r.state != S_IDLE) begin
            r_nxt.state   = S_IDLE;
            r_nxt.error   = r.error;
            r_nxt.timeout = r.timeout;
        end
    end

    always_comb begin
        clean_o   = (r.state == S_CLEAN);
        load_x_o  = (r.state == S_WAIT_X);
        load_y_o  = (r.state == S_WAIT_Y);
        veri_o    = (r.state == S_VERIFY);
        init_o    = (r.state == S_INIT);
        enable_o  = in_calc;
        ready_o   = (r.state == S_READY);
        busy_o    = (r.state != S_IDLE);
        error_o   = r.error;
        timeout_o = r.timeout;
        op_o      = r.op;
        last_o    = cnt_last;
    end

endmodule

// File: tb/tb_mdr_sequencer.sv
// Scoreboard bench for mdr_sequencer: a cycle-schedule model predicts each
// operation's phase profile; a monitor summarises each busy period and compares.
module tb_mdr_sequencer;

    localparam int DW  = 16;
    localparam int CW  = $clog2(DW + 1);
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, load_i, error_i, abort_i;
    logic [1:0]    op_i;
    logic          clean_o, load_x_o, load_y_o, veri_o, init_o, enable_o, ready_o;
    logic          error_o, timeout_o, busy_o, last_o;
    logic [1:0]    op_o;
    logic [CW-1:0] count_o;

    mdr_sequencer #(.DW(DW), .CW(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .load_i(load_i), .op_i(op_i),
        .error_i(error_i), .abort_i(abort_i), .clean_o(clean_o), .load_x_o(load_x_o),
        .load_y_o(load_y_o), .veri_o(veri_o), .init_o(init_o), .enable_o(enable_o),
        .ready_o(ready_o), .error_o(error_o), .timeout_o(timeout_o), .busy_o(busy_o),
        .op_o(op_o), .count_o(count_o), .last_o(last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        bit ready;
        int ready_cyc;
        int n_en;
        int last_at;
        bit loady;
        bit veri;
        bit init;
        bit err;
        bit tmo;
        int end_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Monitor state: one summary per busy period.
    bit m_active = 0;
    int m_cyc, m_en, m_nlast, m_last_at, m_nclean, m_nready, m_ready_cyc;
    bit m_cnt_bad, m_loady, m_veri, m_init, m_early;
    bit g_onehot_bad = 0, g_idle_bad = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_active = 0;
        end else begin
            if ($countones({clean_o, load_x_o, load_y_o, veri_o, init_o, enable_o, ready_o}) > 1)
                g_onehot_bad = 1;
            if (!busy_o && ({clean_o, load_x_o, load_y_o, veri_o, init_o, enable_o, ready_o} != 0
                            || count_o != 0 || last_o))
                g_idle_bad = 1;
            if (!m_active && busy_o) begin
                m_active = 1; m_cyc = 1; m_en = 0; m_nlast = 0; m_last_at = -1;
                m_nclean = 0; m_nready = 0; m_ready_cyc = -1;
                m_cnt_bad = 0; m_loady = 0; m_veri = 0; m_init = 0; m_early = 0;
            end else if (m_active) begin
                m_cyc++;
            end
            if (m_active && busy_o) begin
                if (enable_o) begin
                    if (count_o != CW'(m_en)) m_cnt_bad = 1;
                    if (last_o) begin m_nlast++; m_last_at = m_en; end
                    m_en++;
                end else begin
                    if (count_o != 0) m_cnt_bad = 1;
                    if (last_o) m_nlast++;
                end
                if (clean_o)  m_nclean++;
                if (load_y_o) m_loady = 1;
                if (veri_o)   m_veri = 1;
                if (init_o)   m_init = 1;
                if (ready_o) begin m_nready++; m_ready_cyc = m_cyc; end
                if (error_o || timeout_o) m_early = 1;
            end else if (m_active) begin
                m_active = 0;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_op actual=1 expected=0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("end_cycle",   m_cyc, e.end_cyc);
                    chk("ready_count", m_nready, e.ready ? 1 : 0);
                    chk("ready_cycle", m_ready_cyc, e.ready ? e.ready_cyc : -1);
                    chk("enable_cycles", m_en, e.n_en);
                    chk("count_seq_bad", m_cnt_bad, 0);
                    chk("last_index",  m_last_at, e.last_at);
                    chk("last_count",  m_nlast, (e.last_at >= 0) ? 1 : 0);
                    chk("clean_count", m_nclean, 1);
                    chk("load_y_seen", m_loady, e.loady);
                    chk("veri_seen",   m_veri, e.veri);
                    chk("init_seen",   m_init, e.init);
                    chk("flag_during_busy", m_early, 0);
                    chk("error_o",     error_o, e.err);
                    chk("timeout_o",   timeout_o, e.tmo);
                    chk("op_o",        op_o, e.op);
                end
            end
        end
    end

    // amode: 0 none, 1 abort with load in WAIT_Y, 2 abort in CALC at count k, 3 no loads (timeout)
    task automatic run_op(input int op, input int dx, input int dy, input bit err,
                          input int amode_in, input int k_in, input bit hold_start);
        int   two, iter, c_lx, c_ly, c_lastload, vcyc, abort_c, amode, k;
        bit   fails;
        exp_t e;
        two   = (op == 0 || op == 1);
        iter  = (op == 2) ? (DW + 1) / 2 : DW;
        c_lx  = 2 + dx;
        c_ly  = two ? c_lx + 1 + dy : -1;
        c_lastload = two ? c_ly : c_lx;
        vcyc  = c_lastload + 1;
        fails = err || op == 3;
        amode = amode_in;
        k     = (k_in >= iter) ? iter - 1 : k_in;
        if (amode == 1 && two == 0) amode = 0;
        if (amode == 2 && fails) amode = 0;
        abort_c = -1;
        e = '{op: op, ready: 0, ready_cyc: -1, n_en: 0, last_at: -1, loady: two != 0,
              veri: 0, init: 0, err: 0, tmo: 0, end_cyc: 0};
        case (amode)
            1: begin abort_c = c_ly; e.end_cyc = c_ly + 1; end
            2: begin
                abort_c = vcyc + 2 + k;
                e.end_cyc = abort_c + 1;
                e.veri = 1; e.init = 1; e.n_en = k + 1;
                e.last_at = (k == iter - 1) ? k : -1;
            end
            3: begin
                c_lx = -1; c_ly = -1; c_lastload = 1000; vcyc = -1;
                e.loady = 0; e.err = 1; e.tmo = 1; e.end_cyc = 2 + TMO + 1;
            end
            default: begin
                e.veri = 1;
                if (fails) begin
                    e.err = 1; e.end_cyc = vcyc + 1;
                end else begin
                    e.init = 1; e.n_en = iter; e.last_at = iter - 1;
                    e.ready = 1; e.ready_cyc = vcyc + 2 + iter; e.end_cyc = vcyc + 3 + iter;
                end
            end
        endcase
        sb.push_back(e);
        for (int c = 0; c < e.end_cyc; c++) begin
            start_i = (c == 0) || (hold_start && c >= 2 && c <= c_lx) || ($urandom_range(0, 1) == 1);
            op_i    = (c == 0) ? 2'(op) : 2'($urandom_range(0, 3));
            if (c == c_lx || c == c_ly) load_i = 1'b1;
            else if (c < 2 || c > c_lastload) load_i = ($urandom_range(0, 1) == 1);
            else load_i = 1'b0;
            error_i = (c == vcyc) ? err : ($urandom_range(0, 1) == 1);
            abort_i = (c == abort_c) || (c == 0 && $urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start_i = 1'b0;
            op_i    = 2'($urandom_range(0, 3));
            load_i  = ($urandom_range(0, 1) == 1);
            error_i = ($urandom_range(0, 1) == 1);
            abort_i = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 0; load_i = 0; op_i = 0; error_i = 0; abort_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {clean_o, load_x_o, load_y_o, veri_o, init_o, enable_o, ready_o,
                              error_o, timeout_o, busy_o, op_o, count_o, last_o}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 0, 0, 0, 0, 0, 0);   // MUL, ready in cycle 22
        run_op(2, 0, 0, 0, 0, 0, 0);   // SQRT, ready in cycle 13
        run_op(1, 0, 0, 1, 0, 0, 0);   // DIV with operand error
        run_op(0, 1, 2, 0, 0, 0, 0);   // back-to-back start clears error
        run_op(3, 0, 0, 0, 0, 0, 0);   // reserved op
        run_op(0, 0, 0, 0, 2, 5, 0);   // abort at count 5
        run_op(1, 0, 1, 0, 1, 0, 0);   // abort with load in WAIT_Y
        run_op(2, 2, 0, 0, 2, 7, 0);   // abort on last SQRT iteration
`ifdef MDR_SEQ_TIMEOUT_EN
        run_op(0, 0, 0, 0, 3, 0, 0);
        idle(1);
`endif
        for (int n = 0; n < 40; n++) begin
            run_op($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 2), $urandom_range(0, 15),
                   $urandom_range(0, 1) == 1);
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk("scoreboard_drained", sb.size(), 0);

        // Asynchronous reset in the middle of CALC.
        start_i = 1; op_i = 2'b00; load_i = 0; error_i = 0; abort_i = 0;
        @(posedge clk); #1; start_i = 0;
        @(posedge clk); #1; load_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1; load_i = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("calc_before_reset", {enable_o, count_o}, {1'b1, CW'(3)});
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {clean_o, load_x_o, load_y_o, veri_o, init_o, enable_o, ready_o,
                                    error_o, timeout_o, busy_o, op_o, count_o, last_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1, 3, 0, 0, 0, 0, 1);   // start held through WAIT_X
        idle(3);

        chk("scoreboard_empty", sb.size(), 0);
        chk("monitor_idle", m_active, 0);
        chk("strobes_onehot_bad", g_onehot_bad, 0);
        chk("idle_quiet_bad", g_idle_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
